// File: rtl/multi_digit_seven_segment_driver.sv
// Parametrised multiplexed seven-segment driver for active-low common-anode
// displays. Scans DIGITS digits, each for TICK_CYCLES clocks, with a 16-step
// PWM brightness within every digit slot, per-digit decimal points and blink,
// optional decimal-only decoding and leading-zero blanking.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   values     4 bits per digit, digit 0 (rightmost) in values[3:0]
//   digits     per-digit enable (0 = dark)
//   dp         per-digit decimal point, active-high
//   blink      per-digit blink enable
//   decimal    1: values 10-15 shown as '-' instead of hex A-F
//   lzb        leading-zero blanking enable
//   brightness PWM duty, on-fraction (brightness+1)/16
//   anodes     active-low digit selects, registered
//   cathodes   active-low {DP, CG..CA}, registered
module multi_digit_seven_segment_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned TICK_CYCLES = 400_000,
  parameter int unsigned BLINK_SCANS = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   values,
  input  logic [DIGITS-1:0]     digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  decimal,
  input  logic                  lzb,
  input  logic [3:0]            brightness,
  output logic [DIGITS-1:0]     anodes,
  output logic [7:0]            cathodes
);

  localparam int unsigned SUB_CYCLES = TICK_CYCLES / 16;
  localparam int unsigned SUB_W      = (SUB_CYCLES > 1)  ? $clog2(SUB_CYCLES)  : 1;
  localparam int unsigned IDX_W      = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
  localparam int unsigned SCAN_W     = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  // Standard active-low 0-F font, bits [6:0] = CG..CA.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan state
  logic [SUB_W-1:0]  sub_cnt, sub_cnt_n;
  logic [3:0]        pwm_phase, pwm_phase_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_n;
  logic              blink_phase, blink_phase_n;

  // Per-cycle display decision
  logic [3:0]        val_arr [DIGITS];
  logic [DIGITS-1:0] all_zero;
  logic [3:0]        cur_val;
  logic              sub_last, slot_end, idx_last;
  logic              zero_blank, lit;
  logic [6:0]        seg;
  logic [DIGITS-1:0] anodes_n;
  logic [7:0]        cathodes_n;

  // Next-state for the scan counters
  always_comb begin
    sub_cnt_n     = sub_cnt;
    pwm_phase_n   = pwm_phase;
    idx_n         = idx;
    scan_cnt_n    = scan_cnt;
    blink_phase_n = blink_phase;

    sub_last = (sub_cnt == SUB_W'(SUB_CYCLES - 1));
    slot_end = sub_last && (pwm_phase == 4'hF);
    idx_last = (idx == IDX_W'(DIGITS - 1));

    if (sub_last) begin
      sub_cnt_n   = '0;
      pwm_phase_n = pwm_phase + 4'd1;
    end else begin
      sub_cnt_n = sub_cnt + SUB_W'(1);
    end

    if (slot_end) begin
      if (idx_last) begin
        idx_n = '0;
        if (scan_cnt == SCAN_W'(BLINK_SCANS - 1)) begin
          scan_cnt_n    = '0;
          blink_phase_n = ~blink_phase;
        end else begin
          scan_cnt_n = scan_cnt + SCAN_W'(1);
        end
      end else begin
        idx_n = idx + IDX_W'(1);
      end
    end
  end

  // Output decode for the digit currently being scanned
  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      val_arr[i]  = values[4*i +: 4];
      // Digit i and every digit to its left are zero.
      all_zero[i] = ((values >> (4*i)) == '0);
    end

    cur_val    = val_arr[idx];
    zero_blank = lzb && (idx != '0) && all_zero[idx];

    if (zero_blank)
      seg = 7'h7F;
    else if (decimal && (cur_val >= 4'd10))
      seg = 7'h3F;
    else
      seg = hex_font(cur_val);

    // The last cycle of every slot is kept dark so the registered outputs
    // show all anodes off on the cycle the scan moves to the next digit.
    lit = digits[idx]
          && (pwm_phase <= brightness)
          && !(blink[idx] && blink_phase)
          && !(zero_blank && !dp[idx])
          && !slot_end;

    anodes_n   = '1;
    cathodes_n = 8'hFF;
    if (lit) begin
      anodes_n   = ~(DIGITS'(1) << idx);
      cathodes_n = {~dp[idx], seg};
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt     <= '0;
      pwm_phase   <= '0;
      idx         <= '0;
      scan_cnt    <= '0;
      blink_phase <= 1'b0;
      anodes      <= '1;
      cathodes    <= 8'hFF;
    end else begin
      sub_cnt     <= sub_cnt_n;
      pwm_phase   <= pwm_phase_n;
      idx         <= idx_n;
      scan_cnt    <= scan_cnt_n;
      blink_phase <= blink_phase_n;
      anodes      <= anodes_n;
      cathodes    <= cathodes_n;
    end
  end

endmodule

// File: tb/tb_multi_digit_seven_segment_driver.sv
// Randomised bench for multi_digit_seven_segment_driver. The reference model
// derives the scan position directly from the number of cycles since reset.
module tb_multi_digit_seven_segment_driver;

  localparam int unsigned D  = 4;
  localparam int unsigned T  = 32;
  localparam int unsigned BS = 2;
  localparam int unsigned NCYC = 6000;

  logic             clk = 1'b0;
  logic             rst;
  logic [4*D-1:0]   values;
  logic [D-1:0]     digits, dp, blink;
  logic             decimal, lzb;
  logic [3:0]       brightness;
  logic [D-1:0]     anodes;
  logic [7:0]       cathodes;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_digit_seven_segment_driver #(
    .DIGITS(D), .TICK_CYCLES(T), .BLINK_SCANS(BS)
  ) dut (
    .clk(clk), .rst(rst), .values(values), .digits(digits), .dp(dp),
    .blink(blink), .decimal(decimal), .lzb(lzb), .brightness(brightness),
    .anodes(anodes), .cathodes(cathodes)
  );

  // Full active-low cathode patterns (DP off) for 0-F.
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs registered at the end of state-cycle n (n cycles since reset).
  task automatic model(input int n, output logic [D-1:0] an, output logic [7:0] cat);
    int p, pwm, s, k, bph, v;
    bit zb, on;
    logic [7:0] c;
    p   = n % int'(T);
    pwm = p / int'(T / 16);
    s   = n / int'(T);
    k   = s % int'(D);
    bph = ((s / int'(D)) / int'(BS)) % 2;
    v   = int'((values >> (4*k)) & 16'hF);
    zb  = lzb && (k > 0) && ((values >> (4*k)) == 0);
    on  = digits[k] && (pwm <= int'(brightness)) && !(blink[k] && bph == 1)
          && !(zb && !dp[k]) && (p != int'(T) - 1);
    if (zb)                    c = 8'hFF;
    else if (decimal && v >= 10) c = 8'hBF;
    else                       c = font[v];
    c[7] = ~dp[k];
    an  = on ? D'(~(32'd1 << k)) : '1;
    cat = on ? c : 8'hFF;
  endtask

  task automatic new_inputs();
    for (int i = 0; i < int'(D); i++)
      values[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    digits     = ($urandom_range(0, 1) == 0) ? '1 : D'($urandom);
    dp         = D'($urandom);
    blink      = ($urandom_range(0, 1) == 0) ? '0 : D'($urandom);
    decimal    = 1'($urandom);
    lzb        = 1'($urandom);
    case ($urandom_range(0, 3))
      0:       brightness = 4'd15;
      1:       brightness = 4'd0;
      default: brightness = 4'($urandom_range(0, 15));
    endcase
  endtask

  initial begin
    int n, n_next;
    logic [D-1:0] exp_an;
    logic [7:0]   exp_cat;
    n = 0;
    rst = 1'b1;
    new_inputs();
    for (int c = 0; c < int'(NCYC); c++) begin
      if (c >= 3) rst = ($urandom_range(0, 799) == 0);
      if (c > 0 && $urandom_range(0, 63) == 0) new_inputs();
      if (rst) begin
        exp_an  = '1;
        exp_cat = 8'hFF;
        n_next  = 0;
      end else begin
        model(n, exp_an, exp_cat);
        n_next = n + 1;
      end
      @(posedge clk);
      #1;
      n = n_next;
      check_eq("anodes", 32'(anodes), 32'(exp_an));
      check_eq("cathodes", 32'(cathodes), 32'(exp_cat));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
